// File: rtl/btn_pulse_array_pkg.sv
// Shared constants and helpers for the button debounce / pulse array.
`timescale 1us/1ns
package btn_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_pulse_array_if.sv
// Button bundle: raw inputs in, debounced levels and event strobes out.
`timescale 1us/1ns
interface btn_pulse_array_if
    import btn_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int IDX_W = idx_w(N_CH)
) ();

    logic [N_CH-1:0]  btn_in;
    logic [N_CH-1:0]  btn_level;
    logic [N_CH-1:0]  btn_pulse;
    logic             any_pulse;
    logic [IDX_W-1:0] pulse_idx;
    logic             collision;

    modport master (
        output btn_in,
        input  btn_level, btn_pulse, any_pulse, pulse_idx, collision
    );

    modport slave (
        input  btn_in,
        output btn_level, btn_pulse, any_pulse, pulse_idx, collision
    );

endinterface

// File: rtl/btn_pulse_array_debounce_ch.sv
// One debounce channel: 2-FF synchroniser, stability counter, level and pulse.
`timescale 1us/1ns
module debounce_ch
    import btn_pkg::*;
#(
    parameter int STABLE_CNT = 3,
    parameter int EDGE_MODE  = EDGE_RISE
) (
    input  logic clk_200H,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse
);

    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_lvl;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;
    logic             w_fire;

    // r_s2 is the level about to be accepted, so it tells rise from fall
    assign w_fire = (EDGE_MODE == EDGE_BOTH)
                 || ((EDGE_MODE == EDGE_RISE) == r_s2);

    always_ff @(posedge clk_200H) begin
        if (reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_lvl   <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_btn;
            r_s2    <= r_s1;
            r_pulse <= 1'b0;
            if (r_s2 == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_lvl   <= r_s2;
                r_cnt   <= '0;
                r_pulse <= w_fire;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_lvl;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/btn_pulse_array.sv
// N-channel debouncer with merged strobe, lowest-index encoder and collision flag.
`timescale 1us/1ns
module btn_pulse_array
    import btn_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int STABLE_CNT = 3,
    parameter int EDGE_MODE  = EDGE_RISE
) (
    input  logic            clk_200H,
    input  logic            reset,
    btn_pulse_array_if.slave bus
);

    localparam int IDX_W = idx_w(N_CH);

    logic [N_CH-1:0]  w_level;
    logic [N_CH-1:0]  w_pulse;
    logic [IDX_W-1:0] w_idx;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .STABLE_CNT (STABLE_CNT),
            .EDGE_MODE  (EDGE_MODE)
        ) u_ch (
            .clk_200H (clk_200H),
            .reset    (reset),
            .i_btn    (bus.btn_in[i]),
            .o_level  (w_level[i]),
            .o_pulse  (w_pulse[i])
        );
    end

    // scan high to low so the lowest pulsing channel wins
    always_comb begin
        w_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_pulse[i]) w_idx = IDX_W'(i);
        end
    end

    assign bus.btn_level = w_level;
    assign bus.btn_pulse = w_pulse;
    assign bus.any_pulse = |w_pulse;
    assign bus.pulse_idx = w_idx;
    assign bus.collision = |(w_pulse & (w_pulse - 1'b1));

endmodule

// File: doc/btn_pulse_array.md
# btn_pulse_array

Parametrised multi-channel debouncer and single-pulse generator for mechanical push-button inputs sampled on the 200 Hz system clock. Each channel synchronises its raw input, accepts a new level only after it has been stable for a programmable number of samples, and emits a one-clock pulse on the selected edge(s). A merged strobe with an encoded channel index feeds the downstream Mealy FSM, so the FSM consumes exactly one event per press regardless of contact bounce.

## Interface
Parameters:
- `N_CH`, default 2: number of button channels, ≥1.
- `STABLE_CNT`, default 3: consecutive equal samples required to accept a new level, ≥1.
- `EDGE_MODE`, default 0: 0 = pulse on press (0→1), 1 = pulse on release (1→0), 2 = pulse on both edges.

Ports:
- `clk_200H` in 1: system clock, 200 Hz; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `btn_in` in N_CH: raw asynchronous button inputs, may bounce.
- `btn_level` out N_CH: debounced level per channel.
- `btn_pulse` out N_CH: one-cycle event pulse per channel.
- `any_pulse` out 1: OR of `btn_pulse`.
- `pulse_idx` out IDX_W = max(1, $clog2(N_CH)): index of the lowest-numbered channel pulsing this cycle; 0 when `any_pulse`=0.
- `collision` out 1: more than one bit of `btn_pulse` is high this cycle.

## Operation
- Per channel: 2-FF synchroniser `s1`→`s2`, debounced level register `lvl`, and a stability counter `cnt` of width CNT_W = $clog2(STABLE_CNT+1).
- At each edge:
  - If `s2 == lvl`, `cnt` is set to 0.
  - Otherwise, if `cnt == STABLE_CNT-1`, `lvl` is set to `s2` and `cnt` to 0.
  - Otherwise `cnt` increments.
- Any bounce that returns `s2` to `lvl` restarts the count. `cnt` never exceeds STABLE_CNT-1, so it cannot wrap.
- `btn_pulse[i]` is registered and goes high on the same edge that `lvl` toggles, if that edge type matches EDGE_MODE. It is low in every other cycle and is never high two cycles in a row.
- `btn_level` = `lvl`.
- `any_pulse`, `pulse_idx` and `collision` are combinational from the registered `btn_pulse`, so they are valid in the same cycle.
- Channels are fully independent. Simultaneous events on several channels all appear in `btn_pulse`; `pulse_idx` reports the lowest index and `collision`=1.
- Reset clears `s1`, `s2`, `lvl`, `cnt` and `btn_pulse` to 0, so every output reads 0.
  - Reset mid-count discards the partial count.
  - An input held high through reset release is accepted as a fresh press and produces a pulse in modes 0/2.

## Timing
- Let edge 0 be the first clock edge that samples a new stable input value.
  - `s2` holds it after edge 1.
  - `lvl` toggles and `btn_pulse` asserts at edge STABLE_CNT+1.
  - Latency is STABLE_CNT+1 cycles (4 cycles = 20 ms at defaults).
- Pulse width is exactly 1 cycle.
- Minimum spacing between two pulses on one channel in mode 2 is STABLE_CNT cycles.
- Any input glitch shorter than STABLE_CNT consecutive samples of the new value produces no change on any output.

## Structure
- Shared package `btn_pkg` holds:
  - constants `EDGE_RISE`=0, `EDGE_FALL`=1, `EDGE_BOTH`=2;
  - helper function `idx_w(n)` returning max(1, $clog2(n)).
- Sub-module `debounce_ch` implements one channel: synchroniser, counter, level and pulse register, with parameters STABLE_CNT and EDGE_MODE. It is generated N_CH times.
- The top level contains the generate loop plus the priority encoder and popcount≥2 logic for `pulse_idx` and `collision`.

## Test plan
- **Clean press**, defaults: `btn_in[1]` goes high at t=2.4 ms and is held -> `btn_level[1]`=1 and a single-cycle `btn_pulse[1]` 4 cycles after the first sampling edge; `any_pulse`=1, `pulse_idx`=1, `collision`=0.
- **Bounce**: `btn_in[0]` toggles every 0.5 ms for 4 ms, then is held high -> no pulse during bounce; exactly one pulse STABLE_CNT+1 cycles after the input settles.
- **Short glitch**: a 1-sample high on `btn_in[0]` with STABLE_CNT=3 -> `btn_level`, `btn_pulse` and `cnt` return to 0 with no pulse.
- **Simultaneous press**: `btn_in`=2'b11 on the same edge -> `btn_pulse`=2'b11 for one cycle, `pulse_idx`=0, `collision`=1.
- **Mode and scaling**: EDGE_MODE=2, N_CH=4, STABLE_CNT=5, one press/release on ch 3 -> two pulses, 6 cycles after each clean edge; `pulse_idx`=3 both times.
- **Reset**: reset asserted after 2 of 3 stable samples -> all outputs 0 and count lost. Input held high through reset release -> pulse 4 cycles after release.
